// File: rtl/uart_arbiter.sv
// uart_arbiter: shares one UART transfer port between two requesters.
// Round-robin owner selection in IDLE, request issue until the UART accepts,
// then wait for completion. Per-requester accept/done pulses are combinational
// copies of the UART pulses, steered to the current owner only.
module uart_arbiter #(
    parameter int LEN_WORD = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                r0_order,
    input  logic [1:0]          r0_size,
    input  logic                r0_write,
    input  logic [LEN_WORD-1:0] r0_o_data,
    output logic                r0_accepted,
    output logic                r0_done,
    output logic [LEN_WORD-1:0] r0_r_data,
    input  logic                r1_order,
    input  logic [1:0]          r1_size,
    input  logic                r1_write,
    input  logic [LEN_WORD-1:0] r1_o_data,
    output logic                r1_accepted,
    output logic                r1_done,
    output logic [LEN_WORD-1:0] r1_r_data,
    output logic                uart_order,
    output logic [1:0]          uart_size,
    output logic                uart_write,
    output logic [LEN_WORD-1:0] uart_o_data,
    input  logic                uart_accepted,
    input  logic                uart_done,
    input  logic [LEN_WORD-1:0] uart_r_data,
    output logic                grant,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                last_owner;
    logic                pick;
    logic                any_order;
    logic                xfer_end;
    logic [1:0]          lat_size;
    logic                lat_write;
    logic [LEN_WORD-1:0] lat_data;

    // Owner selection: on a tie the requester that did not own last wins.
    always_comb begin
        any_order = r0_order | r1_order;
        if (r0_order && r1_order)
            pick = ~last_owner;
        else
            pick = r1_order;
        // A transfer ends on done in WAIT, or on accept+done together in ISSUE.
        xfer_end = ((state == ISSUE) && uart_accepted && uart_done) ||
                   ((state == WAIT) && uart_done);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; UART pulses in IDLE and accepts in WAIT are ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_order) state_nxt = ISSUE;
            ISSUE:   if (uart_accepted) state_nxt = uart_done ? IDLE : WAIT;
            WAIT:    if (uart_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, round-robin history and the latched transfer fields.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            grant      <= 1'b0;
            last_owner <= 1'b1;
            lat_size   <= 2'b00;
            lat_write  <= 1'b0;
            lat_data   <= '0;
        end else begin
            if ((state == IDLE) && any_order) begin
                grant     <= pick;
                lat_size  <= pick ? r1_size   : r0_size;
                lat_write <= pick ? r1_write  : r0_write;
                lat_data  <= pick ? r1_o_data : r0_o_data;
            end
            if (xfer_end)
                last_owner <= grant;
        end
    end

    // UART request side and per-requester pulse/data steering.
    always_comb begin
        busy        = (state != IDLE);
        uart_order  = (state == ISSUE);
        uart_write  = busy ? lat_write : 1'b0;
        uart_size   = lat_size;
        uart_o_data = lat_data;
        r0_accepted = uart_accepted && (state == ISSUE) && !grant;
        r1_accepted = uart_accepted && (state == ISSUE) && grant;
        r0_done     = uart_done && busy && !grant;
        r1_done     = uart_done && busy && grant;
        r0_r_data   = (busy && !grant) ? uart_r_data : '0;
        r1_r_data   = (busy && grant)  ? uart_r_data : '0;
    end

endmodule

// File: tb/tb_uart_arbiter.sv
// Testbench for uart_arbiter: a directed vector table walking the main
// scenarios, then randomized traffic, both checked against a transaction-level
// reference model (owner, fields, "accepted yet" flag).
module tb_uart_arbiter;

    localparam int LW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          r0_order, r1_order, r0_write, r1_write;
    logic [1:0]    r0_size, r1_size;
    logic [LW-1:0] r0_o_data, r1_o_data;
    logic          r0_accepted, r1_accepted, r0_done, r1_done;
    logic [LW-1:0] r0_r_data, r1_r_data;
    logic          uart_order, uart_write;
    logic [1:0]    uart_size;
    logic [LW-1:0] uart_o_data;
    logic          uart_accepted, uart_done;
    logic [LW-1:0] uart_r_data;
    logic          grant, busy;

    always #5 clk = ~clk;

    uart_arbiter #(.LEN_WORD(LW)) dut (
        .clk(clk), .rstn(rstn),
        .r0_order(r0_order), .r0_size(r0_size), .r0_write(r0_write),
        .r0_o_data(r0_o_data), .r0_accepted(r0_accepted), .r0_done(r0_done),
        .r0_r_data(r0_r_data),
        .r1_order(r1_order), .r1_size(r1_size), .r1_write(r1_write),
        .r1_o_data(r1_o_data), .r1_accepted(r1_accepted), .r1_done(r1_done),
        .r1_r_data(r1_r_data),
        .uart_order(uart_order), .uart_size(uart_size), .uart_write(uart_write),
        .uart_o_data(uart_o_data), .uart_accepted(uart_accepted),
        .uart_done(uart_done), .uart_r_data(uart_r_data),
        .grant(grant), .busy(busy)
    );

    // Reference model: a transfer is either absent, or present with an
    // owner and "already accepted" flag.
    bit          m_busy = 1'b0;
    bit          m_acc  = 1'b0;
    bit          m_grant = 1'b0;
    bit          m_last = 1'b1;
    logic [1:0]  m_size = 2'b00;
    bit          m_write = 1'b0;
    logic [LW-1:0] m_data = '0;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [6:0] in_bits;   // {rstn, r0_order, r1_order, r0_write, r1_write, uart_accepted, uart_done}
        logic [6:0] exp_bits;  // {uart_order, grant, busy, r0_acc, r1_acc, r0_done, r1_done}
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_check(input string tag);
        logic [10:0]   exp_ctl;
        logic [10:0]   act_ctl;
        logic [LW-1:0] e_r0, e_r1;
        bit            issuing;
        issuing = m_busy && !m_acc;
        exp_ctl = {issuing, m_grant, m_busy, (m_busy ? m_write : 1'b0), m_size,
                   uart_accepted && issuing && !m_grant,
                   uart_accepted && issuing && m_grant,
                   uart_done && m_busy && !m_grant,
                   uart_done && m_busy && m_grant, 1'b0};
        act_ctl = {uart_order, grant, busy, uart_write, uart_size,
                   r0_accepted, r1_accepted, r0_done, r1_done, 1'b0};
        check({tag, "_ctl"}, 128'(act_ctl), 128'(exp_ctl));
        e_r0 = (m_busy && !m_grant) ? uart_r_data : '0;
        e_r1 = (m_busy && m_grant)  ? uart_r_data : '0;
        check({tag, "_data"}, 128'({uart_o_data, r0_r_data, r1_r_data}),
              128'({m_data, e_r0, e_r1}));
    endtask

    task automatic model_update();
        if (!rstn) begin
            m_busy = 0; m_acc = 0; m_grant = 0; m_last = 1;
            m_size = '0; m_write = 0; m_data = '0;
        end else if (!m_busy) begin
            if (r0_order || r1_order) begin
                if (r0_order && r1_order) m_grant = !m_last;
                else                      m_grant = r1_order;
                m_size  = m_grant ? r1_size   : r0_size;
                m_write = m_grant ? r1_write  : r0_write;
                m_data  = m_grant ? r1_o_data : r0_o_data;
                m_busy  = 1; m_acc = 0;
            end
        end else if (!m_acc) begin
            if (uart_accepted && uart_done) begin
                m_busy = 0; m_last = m_grant;
            end else if (uart_accepted) begin
                m_acc = 1;
            end
        end else if (uart_done) begin
            m_busy = 0; m_last = m_grant;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        tbl[0]  = '{7'b0000000, 7'b0000000};  // reset state
        tbl[1]  = '{7'b1101000, 7'b0000000};  // r0 write request, IDLE
        tbl[2]  = '{7'b1101000, 7'b1010000};  // ISSUE, uart_order high
        tbl[3]  = '{7'b1001010, 7'b1011000};  // r0 drops order, accept -> r0 only
        tbl[4]  = '{7'b1001000, 7'b0010000};  // WAIT
        tbl[5]  = '{7'b1001001, 7'b0010010};  // done -> r0_done
        tbl[6]  = '{7'b1000000, 7'b0000000};  // busy fell
        tbl[7]  = '{7'b0000000, 7'b0000000};  // reset again
        tbl[8]  = '{7'b1111100, 7'b0000000};  // tie -> r0 chosen
        tbl[9]  = '{7'b1111111, 7'b1011010};  // accept+done same cycle
        tbl[10] = '{7'b1111100, 7'b0000000};  // IDLE one cycle, tie -> r1
        tbl[11] = '{7'b1111110, 7'b1110100};  // r1 accepted
        tbl[12] = '{7'b1111101, 7'b0110001};  // r1 done
        tbl[13] = '{7'b1111100, 7'b0100000};  // IDLE, tie -> r0
        tbl[14] = '{7'b1111110, 7'b1011000};  // r0 accepted -> WAIT
        tbl[15] = '{7'b0000000, 7'b0010000};  // reset asserted in WAIT
        tbl[16] = '{7'b1000001, 7'b0000000};  // late uart_done ignored
        tbl[17] = '{7'b1010000, 7'b0000000};  // r1 read request
        tbl[18] = '{7'b1000010, 7'b1110100};  // r1 accepted
        tbl[19] = '{7'b1000001, 7'b0110001};  // r1 done with read data
        tbl[20] = '{7'b1000011, 7'b0100000};  // spurious pulses in IDLE
        tbl[21] = '{7'b1000011, 7'b0100000};

        rstn = 0; r0_order = 0; r1_order = 0; r0_write = 0; r1_write = 0;
        r0_size = 2'b10; r1_size = 2'b01;
        r0_o_data = 32'haa; r1_o_data = 32'h55;
        uart_accepted = 0; uart_done = 0; uart_r_data = 32'h12345678;
        tick();
        tick();

        // Directed vector table
        for (int i = 0; i < 22; i++) begin
            {rstn, r0_order, r1_order, r0_write, r1_write, uart_accepted, uart_done} = tbl[i].in_bits;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  128'({uart_order, grant, busy, r0_accepted, r1_accepted, r0_done, r1_done}),
                  128'(tbl[i].exp_bits));
            model_check($sformatf("vec%0d_model", i));
            if (i == 2)
                check("single_req_data", 128'({uart_o_data, uart_size, uart_write}),
                      128'({32'haa, 2'b10, 1'b1}));
            if (i == 19)
                check("rx_data", 128'({r1_r_data, r0_r_data}), 128'({32'h12345678, 32'h0}));
            tick();
        end

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            rstn          = ($urandom_range(0, 59) != 0);
            r0_order      = $urandom_range(0, 1) == 1;
            r1_order      = $urandom_range(0, 1) == 1;
            r0_write      = $urandom_range(0, 1) == 1;
            r1_write      = $urandom_range(0, 1) == 1;
            r0_size       = 2'($urandom_range(0, 3));
            r1_size       = 2'($urandom_range(0, 3));
            r0_o_data     = $urandom;
            r1_o_data     = $urandom;
            uart_accepted = $urandom_range(0, 3) == 0;
            uart_done     = $urandom_range(0, 3) == 0;
            uart_r_data   = $urandom;
            @(negedge clk);
            model_check("rand");
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_arbiter.md
UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 SHALL have parameter LEN_WORD, default 32, the data word width.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rstn, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have ports r0_order / r1_order, input, 1 each, a level request from requester 0 / 1.
REQ-005 SHALL have ports r0_size / r1_size, input, 2 each, the transfer size code.
REQ-006 SHALL have ports r0_write / r1_write, input, 1 each: 1 = transmit, 0 = receive.
REQ-007 SHALL have ports r0_o_data / r1_o_data, input, LEN_WORD each, the transmit data.
REQ-008 SHALL have ports r0_accepted / r1_accepted, output, 1 each, an accept pulse to the owner.
REQ-009 SHALL have ports r0_done / r1_done, output, 1 each, a completion pulse to the owner.
REQ-010 SHALL have ports r0_r_data / r1_r_data, output, LEN_WORD each, the received data; valid only with that requester's done.
REQ-011 SHALL have port uart_order, output, 1, the request to the shared UART.
REQ-012 SHALL have port uart_size, output, 2, the size to the shared UART.
REQ-013 SHALL have port uart_write, output, 1, the direction to the shared UART.
REQ-014 SHALL have port uart_o_data, output, LEN_WORD, the transmit data to the shared UART.
REQ-015 SHALL have port uart_accepted, input, 1, a UART accept pulse.
REQ-016 SHALL have port uart_done, input, 1, a UART completion pulse.
REQ-017 SHALL have port uart_r_data, input, LEN_WORD, UART receive data; valid with uart_done.
REQ-018 SHALL have port grant, output, 1, the current owner index (0/1).
REQ-019 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-020 SHALL implement the states IDLE, ISSUE and WAIT (one-hot or binary encoding is acceptable).
REQ-021 SHALL, in IDLE with at least one rN_order high, select the owner round-robin, latch the owner's size/write/o_data into registers, set grant, and enter ISSUE on the next edge.
REQ-022 Round-robin rule SHALL be: if both requesters are requesting, pick the one that is not last_owner; if only one is requesting, pick that one; last_owner resets to 1, so requester 0 wins the first tie.
REQ-023 SHALL, in ISSUE, drive uart_order=1 with uart_size/uart_write/uart_o_data from the latched registers, held stable until uart_accepted.
REQ-024 SHALL, in ISSUE on uart_accepted=1 with uart_done=0, drop uart_order and enter WAIT on the next edge.
REQ-025 SHALL, in ISSUE when uart_accepted=1 and uart_done=1 arrive in the same cycle, treat the transfer as complete and enter IDLE.
REQ-026 SHALL, in WAIT on uart_done=1, enter IDLE and update last_owner to grant.
REQ-027 SHALL, on a complete per REQ-025, also update last_owner to grant.
REQ-028 SHALL drive rN_accepted = uart_accepted AND (state==ISSUE) AND (grant==N), combinationally with zero latency.
REQ-029 SHALL drive rN_done = uart_done AND (state is ISSUE or WAIT) AND (grant==N), combinationally.
REQ-030 SHALL drive rN_r_data = uart_r_data for the owner and 0 for the non-owner.
REQ-031 SHALL, in IDLE, drive uart_order=0 and uart_write=0; uart_size and uart_o_data hold their last latched values.
REQ-032 SHALL ignore uart_accepted and uart_done while in IDLE: no state change and no pulse to any requester.
REQ-033 SHALL, in WAIT, ignore a spurious uart_accepted.
REQ-034 SHALL NOT affect an in-flight transfer when the owner drops rN_order after the grant; the latched fields complete the transfer.
REQ-035 SHALL keep a requester that is still high after its done eligible; it is re-arbitrated in IDLE on the following cycle, so IDLE lasts at least 1 cycle between transfers.
REQ-036 SHALL have a minimum grant-to-uart_order latency of 1 cycle (request seen in IDLE, uart_order high on the next cycle).

Reset
REQ-037 SHALL, when rstn=0 at a clock edge, set: state=IDLE, grant=0, last_owner=1, latched size/write/o_data=0, uart_order=0, busy=0, and all rN_accepted/rN_done=0.
REQ-038 SHALL, on a reset mid-transfer (ISSUE or WAIT), abandon the transfer; neither requester receives done.
REQ-039 SHALL ignore a late uart_done that arrives after the reset released (the state is IDLE, per REQ-032).

Verification
REQ-040 Single request: r0 requests write with o_data=32'haa, size=2'b10 -> uart_order high 1 cycle later with data 32'haa; accepted pulse appears on r0_accepted only; done appears on r0_done; busy then falls.
REQ-041 Contention: r0 and r1 request in the same cycle after reset -> r0 is served first, then r1 (grant=1); after r1 completes, both requesting again -> r0 is served.
REQ-042 Receive path: r1 issues a read, and uart_done arrives with uart_r_data=32'h12345678 -> r1_r_data=32'h12345678 with r1_done=1, while r0_r_data=0 and r0_done=0.
REQ-043 Same-cycle accept and done in ISSUE -> both owner pulses occur in that cycle and the state is IDLE on the next cycle.
REQ-044 Reset in WAIT, then uart_done one cycle after the reset releases -> no rN_done pulse and busy=0.
REQ-045 Spurious uart_accepted/uart_done while in IDLE with no requests -> no outputs change.
